// File: rtl/counter_pkg.sv
// Shared encodings for the counter sequencer: FSM states, run modes, default width.
package counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_OS_UP = 2'b00,
    M_FR_UP = 2'b01,
    M_OS_DN = 2'b10,
    M_FR_DN = 2'b11
  } mode_t;

  // Bit 1 of the mode selects direction, bit 0 selects free-run.
  function automatic logic mode_is_down(input mode_t m);
    return m[1];
  endfunction

  function automatic logic mode_is_free(input mode_t m);
    return m[0];
  endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Command/status bundle between top-level control and the counter sequencer.
interface counter_sequencer_if #(parameter int WIDTH = 4);
  logic             start;
  logic             stop;
  logic             pause;
  logic [1:0]       mode;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (output start, stop, pause, mode, limit,
                  input  q, busy, done, wrap);
  modport slave  (input  start, stop, pause, mode, limit,
                  output q, busy, done, wrap);
endinterface

// File: rtl/counter_core.sv
// Counter datapath register: synchronous load beats step, step direction from dir.
import counter_pkg::*;

module counter_core #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (en)
      q <= dir ? q + 1'b1 : q - 1'b1;
  end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer FSM driving counter_core; registers BUSY and the DONE/WRAP pulses.
//   state  | meaning
//   IDLE   | stopped, Q holds
//   RUN    | stepping once per edge
//   HOLD   | paused, Q holds until PAUSE drops
//   FINISH | one-shot complete, Q holds terminal value
import counter_pkg::*;

module counter_sequencer #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_sequencer_if.slave bus
);

  state_t           state, state_next;
  mode_t            mode_r;
  logic [WIDTH-1:0] lim_r;
  logic             latch;
  logic             core_en, core_dir, core_load;
  logic [WIDTH-1:0] core_load_val;
  logic             done_next, wrap_next;
  logic             at_term;

  // Terminal point depends on direction: lim_r counting up, zero counting down.
  assign at_term = mode_is_down(mode_r) ? (bus.q == '0) : (bus.q == lim_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_r   <= M_OS_UP;
      lim_r    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.wrap <= 1'b0;
    end else begin
      state    <= state_next;
      bus.busy <= (state_next == RUN) || (state_next == HOLD);
      bus.done <= done_next;
      bus.wrap <= wrap_next;
      if (latch) begin
        mode_r <= mode_t'(bus.mode);
        lim_r  <= bus.limit;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (bus.stop)
      state_next = IDLE;
    else begin
      case (state)
        IDLE, FINISH: if (bus.start) state_next = RUN;
        RUN: begin
          if (bus.pause)
            state_next = HOLD;
          else if (at_term && !mode_is_free(mode_r))
            state_next = FINISH;
        end
        HOLD: if (!bus.pause) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    latch         = 1'b0;
    core_en       = 1'b0;
    core_dir      = 1'b1;
    core_load     = 1'b0;
    core_load_val = '0;
    done_next     = 1'b0;
    wrap_next     = 1'b0;
    if (bus.stop)
      core_load = 1'b1;
    else begin
      case (state)
        IDLE, FINISH: begin
          if (bus.start) begin
            latch         = 1'b1;
            core_load     = 1'b1;
            core_load_val = bus.mode[1] ? bus.limit : '0;
          end
        end
        RUN: begin
          if (!bus.pause) begin
            if (!at_term) begin
              core_en  = 1'b1;
              core_dir = !mode_is_down(mode_r);
            end else if (!mode_is_free(mode_r))
              done_next = 1'b1;
            else begin
              core_load     = 1'b1;
              core_load_val = mode_is_down(mode_r) ? lim_r : '0;
              wrap_next     = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (core_en),
    .dir      (core_dir),
    .load     (core_load),
    .load_val (core_load_val),
    .q        (bus.q)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: vector table plus hand-written reset sequences.
module tb_counter_sequencer;

  typedef struct {
    logic       start, stop, pause;
    logic [1:0] mode;
    logic [3:0] limit;
    logic [3:0] q;
    logic       busy, done, wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t vq[$];

  counter_sequencer_if #(.WIDTH(4)) bus ();

  counter_sequencer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic pa, input logic [1:0] m,
                     input logic [3:0] l, input logic [3:0] eq, input logic eb,
                     input logic ed, input logic ew);
    vec_t v;
    v.start = st; v.stop = sp; v.pause = pa; v.mode = m; v.limit = l;
    v.q = eq; v.busy = eb; v.done = ed; v.wrap = ew;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa,
                       input logic [1:0] m, input logic [3:0] l);
    bus.start = st; bus.stop = sp; bus.pause = pa; bus.mode = m; bus.limit = l;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [3:0] eq,
                           input logic eb, input logic ed, input logic ew);
    chk({tag, "_q"},    idx, int'(bus.q),    int'(eq));
    chk({tag, "_busy"}, idx, int'(bus.busy), int'(eb));
    chk({tag, "_done"}, idx, int'(bus.done), int'(ed));
    chk({tag, "_wrap"}, idx, int'(bus.wrap), int'(ew));
  endtask

  initial begin
    drive(0, 0, 0, 2'b00, 4'd0);

    // One-shot up, LIMIT=5: Q 0..5, DONE after the sixth RUN edge, then FINISH holds 5.
    add(1, 0, 0, 2'b00, 4'd5, 4'd0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, 0, 2'b00, 4'd5, 4'(i), 1, 0, 0);
    add(0, 0, 0, 2'b00, 4'd5, 4'd5, 0, 1, 0);
    add(0, 0, 0, 2'b00, 4'd5, 4'd5, 0, 0, 0);
    // One-shot down, LIMIT=3, pause two cycles at Q=2; restart from FINISH.
    add(1, 0, 0, 2'b10, 4'd3, 4'd3, 1, 0, 0);
    add(0, 0, 0, 2'b10, 4'd3, 4'd2, 1, 0, 0);
    add(0, 0, 1, 2'b10, 4'd3, 4'd2, 1, 0, 0);
    add(0, 0, 1, 2'b10, 4'd3, 4'd2, 1, 0, 0);
    add(0, 0, 0, 2'b10, 4'd3, 4'd2, 1, 0, 0);
    add(0, 0, 0, 2'b10, 4'd3, 4'd1, 1, 0, 0);
    add(0, 0, 0, 2'b10, 4'd3, 4'd0, 1, 0, 0);
    add(0, 0, 0, 2'b10, 4'd3, 4'd0, 0, 1, 0);
    // STOP and START together at Q=7.
    add(1, 0, 0, 2'b01, 4'd15, 4'd0, 1, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 2'b01, 4'd15, 4'(i), 1, 0, 0);
    add(1, 1, 0, 2'b01, 4'd15, 4'd0, 0, 0, 0);
    add(0, 0, 0, 2'b01, 4'd15, 4'd0, 0, 0, 0);
    // Free-run up, LIMIT=15; a START with other MODE/LIMIT mid-run must be ignored.
    add(1, 0, 0, 2'b01, 4'd15, 4'd0, 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) add(1, 0, 0, 2'b00, 4'd3, 4'(i), 1, 0, 0);
      else        add(0, 0, 0, 2'b01, 4'd15, 4'(i), 1, 0, 0);
    end
    add(0, 0, 0, 2'b01, 4'd15, 4'd0, 1, 0, 1);
    add(0, 0, 0, 2'b01, 4'd15, 4'd1, 1, 0, 0);
    add(0, 1, 0, 2'b01, 4'd15, 4'd0, 0, 0, 0);
    // LIMIT=0: free-run wraps every edge, one-shot finishes on first edge.
    add(1, 0, 0, 2'b01, 4'd0, 4'd0, 1, 0, 0);
    add(0, 0, 0, 2'b01, 4'd0, 4'd0, 1, 0, 1);
    add(0, 0, 0, 2'b01, 4'd0, 4'd0, 1, 0, 1);
    add(0, 1, 0, 2'b01, 4'd0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 2'b00, 4'd0, 4'd0, 1, 0, 0);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 1, 0);
    add(0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0, 0);
    // Free-run down, LIMIT=2: 2,1,0 then reload 2 with WRAP.
    add(1, 0, 0, 2'b11, 4'd2, 4'd2, 1, 0, 0);
    add(0, 0, 0, 2'b11, 4'd2, 4'd1, 1, 0, 0);
    add(0, 0, 0, 2'b11, 4'd2, 4'd0, 1, 0, 0);
    add(0, 0, 0, 2'b11, 4'd2, 4'd2, 1, 0, 1);
    add(0, 0, 0, 2'b11, 4'd2, 4'd1, 1, 0, 0);
    add(0, 1, 0, 2'b11, 4'd2, 4'd0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 4'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].start, vq[i].stop, vq[i].pause, vq[i].mode, vq[i].limit);
      @(posedge clk);
      #1;
      check_all("vec", i, vq[i].q, vq[i].busy, vq[i].done, vq[i].wrap);
    end

    // Async reset between edges while counting, Q=9.
    drive(1, 0, 0, 2'b01, 4'd15);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 2'b01, 4'd15);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_q", 0, int'(bus.q), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_q", 0, int'(bus.q), 0);
    chk("async_busy", 0, int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all("post_rst", i, 4'd0, 0, 0, 0);
    end

    // A fresh START after reset runs normally from 0.
    drive(1, 0, 0, 2'b00, 4'd2);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 2'b00, 4'd2);
    check_all("restart", 0, 4'd0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_all("restart", 1, 4'd2, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences a WIDTH-bit up/down counter datapath.
- Accepts start, stop and pause commands and a programmable terminal value (LIMIT).
- Supports one-shot and free-run modes and reports BUSY, DONE and WRAP status.
- Sits between the top-level control logic and the counter output Q that drives the display/compare logic.

Parameters:
- WIDTH, 4, counter and LIMIT width in bits.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  start/restart command, sampled on the rising edge
- STOP  input  1  abort command; takes priority over START
- PAUSE  input  1  level; while high in RUN, the count holds
- MODE  input  2  00 one-shot up, 01 free-run up, 10 one-shot down, 11 free-run down
- LIMIT  input  WIDTH  terminal value
- Q  output  WIDTH  counter value (registered)
- BUSY  output  1  high in RUN or HOLD
- DONE  output  1  one-cycle pulse on one-shot completion
- WRAP  output  1  one-cycle pulse on free-run wrap

Behaviour:
- Reset (RST_N low, async): state IDLE; Q=0, BUSY=0, DONE=0, WRAP=0. The latched MODE and LIMIT are cleared to 0.
- All outputs are registered.
- DONE and WRAP default to 0 every cycle unless set by the rules below.
- States:
  - IDLE: Q holds its value.
  - RUN
  - HOLD
  - FINISH: Q holds at its terminal value.
- START with STOP low, in IDLE or FINISH:
  - latch MODE and LIMIT as mode_r and lim_r;
  - Q <= 0 for up modes, Q <= LIMIT for down modes;
  - go to RUN.
  - START in RUN or HOLD is ignored; mode_r and lim_r are not re-latched.
- STOP in any state: Q <= 0, go to IDLE, DONE=0, WRAP=0. STOP wins over START and PAUSE.
- RUN with PAUSE high: go to HOLD, Q unchanged.
- HOLD with PAUSE low: return to RUN. No step occurs on the edge that leaves HOLD; stepping resumes on the next edge.
- RUN step, up mode:
  - Q != lim_r: Q <= Q+1.
  - Q == lim_r, one-shot: no increment; DONE <= 1; go to FINISH.
  - Q == lim_r, free-run: Q <= 0; WRAP <= 1.
- RUN step, down mode:
  - Q != 0: Q <= Q-1.
  - Q == 0, one-shot: DONE <= 1; go to FINISH.
  - Q == 0, free-run: Q <= lim_r; WRAP <= 1.
- Latency, one-shot up: START edge at cycle k, Q=1 at k+1, Q=lim_r at k+lim_r, DONE high in the cycle after edge k+lim_r+1.
- Free-run period: lim_r+1 cycles.
- lim_r=0:
  - one-shot: DONE fires on the first RUN edge;
  - free-run: WRAP fires on every RUN edge and Q stays 0.
- Arithmetic: modulo 2^WIDTH. The terminal compare makes overflow unreachable.
- BUSY = (state==RUN || state==HOLD), registered alongside the state.
- Reset asserted mid-count: immediate return to the reset values, with no DONE or WRAP.

Decomposition:
- Shared package, counter_pkg:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, HOLD=2'd2, FINISH=2'd3;
  - MODE constants: M_OS_UP, M_FR_UP, M_OS_DN, M_FR_DN;
  - default WIDTH.
- Sub-module counter_core: the datapath register.
  - Inputs: CLK, RST_N, EN, DIR, LOAD, LOAD_VAL.
  - Output: Q.
  - LOAD has priority over EN.
- counter_sequencer instantiates counter_core and contains the FSM and the pulse logic.

Test Plan:
- Free-run up: reset, then START, MODE=01, LIMIT=15, run 16 RUN edges -> Q steps 0..15 and returns to 0. WRAP is high for exactly one cycle as Q becomes 0. BUSY stays 1 throughout.
- One-shot up: START, MODE=00, LIMIT=5 -> Q=1..5 on edges k+1..k+5. DONE is high for 1 cycle after edge k+6. State goes to FINISH, Q holds 5, BUSY=0.
- One-shot down with pause: START, MODE=10, LIMIT=3, PAUSE high for 2 cycles when Q=2 -> Q holds 2 for 3 cycles, then Q=1, 0, then DONE. Q ends at 0.
- STOP/START collision: in RUN with Q=7, assert START and STOP together -> next edge Q=0, state IDLE, BUSY=0, no DONE or WRAP.
- Async reset mid-count: drive RST_N low between clock edges while Q=9 -> Q=0 and BUSY=0 immediately, without waiting for CLK. The count stays 0 until the next START.
- lim_r=0 edge cases: free-run up with LIMIT=0 -> Q stays 0 and WRAP is high every cycle. Then STOP, then one-shot with LIMIT=0 -> DONE on the first edge after START.
